pipe_skid_stage: RTL and testbench

- Elastic valid/ready pipeline register that sits directly upstream of the delay line and feeds its dataIn/en_n.
- Absorbs one beat of backpressure through a skid entry, so the producer never sees a combinational ready path.
- Converts the downstream handshake into the active-low enable the delay line consumes.
- Payload width matches the delay line: BIT_WIDTH*DEPTH.

---
 rtl/pipe_skid_stage_if.sv | 12 +
 rtl/pipe_skid_stage.sv | 99 +++++++++
 tb/tb_pipe_skid_stage.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/pipe_skid_stage_if.sv
// Valid/ready/data channel used on both sides of pipe_skid_stage.
// master drives valid/data, slave drives ready.
interface pipe_skid_stage_if #(
    parameter int unsigned W = 6
) ();
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave (input valid, input data, output ready);
endinterface

// File: rtl/pipe_skid_stage.sv
// Elastic valid/ready register with one skid entry, feeding the delay line dataIn/en_n.
// Optional synchronous flush port enabled by defining PIPE_SKID_FLUSH_EN.
module pipe_skid_stage #(
    parameter int unsigned                 BIT_WIDTH  = 2,
    parameter int unsigned                 DEPTH      = 3,
    parameter logic [BIT_WIDTH*DEPTH-1:0]  RESET_DATA = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
`ifdef PIPE_SKID_FLUSH_EN
    input  logic                    flush,
`endif
    pipe_skid_stage_if.slave        in_if,
    pipe_skid_stage_if.master       out_if,
    output logic                    out_en_n,
    output logic [1:0]              occupancy
);
    localparam int unsigned W = BIT_WIDTH * DEPTH;

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StBusy  = 2'd1,
        StFull  = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic           in_ready_q, in_ready_d;
    logic [W-1:0]   main_q, main_d;
    logic [W-1:0]   skid_q, skid_d;
    logic           in_fire, out_fire, out_valid, flush_now;

`ifdef PIPE_SKID_FLUSH_EN
    assign flush_now = flush;
`else
    assign flush_now = 1'b0;
`endif

    assign out_valid = (state_q != StEmpty);
    assign in_fire   = in_if.valid & in_ready_q;
    assign out_fire  = out_valid & out_if.ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            StEmpty: begin
                if (in_fire) begin
                    main_d  = in_if.data;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (in_fire && out_fire) begin
                    main_d = in_if.data;
                end else if (in_fire) begin
                    skid_d  = in_if.data;
                    state_d = StFull;
                end else if (out_fire) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                if (out_fire) begin
                    main_d  = skid_q;
                    state_d = StBusy;
                end
            end
            default: state_d = StEmpty;
        endcase
        // Flush drops held beats and any incoming beat but leaves data registers untouched.
        if (flush_now) begin
            state_d = StEmpty;
            main_d  = main_q;
            skid_d  = skid_q;
        end
        in_ready_d = (state_d != StFull);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StEmpty;
            in_ready_q <= 1'b1;
            main_q     <= RESET_DATA;
            skid_q     <= RESET_DATA;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
        end
    end

    assign in_if.ready  = in_ready_q;
    assign out_if.valid = out_valid;
    assign out_if.data  = main_q;
    assign occupancy    = state_q;
    assign out_en_n     = ~out_fire | flush_now;
endmodule

// File: tb/tb_pipe_skid_stage.sv
// Scoreboard bench for pipe_skid_stage: the driver queues accepted beats, a negedge monitor
// checks status against a beat-count model and pops/compares every emitted beat.
module tb_pipe_skid_stage;
    localparam int unsigned W = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       out_en_n;
    logic [1:0] occupancy;
`ifdef PIPE_SKID_FLUSH_EN
    logic       flush = 1'b0;
`endif

    pipe_skid_stage_if #(.W(W)) in_bus ();
    pipe_skid_stage_if #(.W(W)) out_bus ();

    pipe_skid_stage #(
        .BIT_WIDTH  (2),
        .DEPTH      (3),
        .RESET_DATA (6'b000000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef PIPE_SKID_FLUSH_EN
        .flush     (flush),
`endif
        .in_if     (in_bus),
        .out_if    (out_bus),
        .out_en_n  (out_en_n),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    int           n_checks = 0;
    int           n_fail = 0;
    logic [W-1:0] exp_q[$];   // beats accepted and not yet emitted, oldest first
    int           cnt = 0;    // beats currently held by the stage
    bit           mon_en = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit v, input logic [W-1:0] d, input bit r, input bit f,
                        output bit acc);
        @(posedge clk);
        #2;
        in_bus.valid  = v;
        in_bus.data   = d;
        out_bus.ready = r;
`ifdef PIPE_SKID_FLUSH_EN
        flush = f;
`endif
        acc = v && (cnt < 2) && !f;
        if (acc) exp_q.push_back(d);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_out_valid"}, out_bus.valid, 1'b0);
        chk({tag, "_in_ready"}, in_bus.ready, 1'b1);
        chk({tag, "_occupancy"}, occupancy, 2'd0);
        chk({tag, "_out_data"}, out_bus.data, 6'b000000);
        chk({tag, "_out_en_n"}, out_en_n, 1'b1);
    endtask

    always @(negedge clk) begin
        bit f;
        bit ifire;
        bit ofire;
        if (mon_en) begin
            f = 1'b0;
`ifdef PIPE_SKID_FLUSH_EN
            f = flush;
`endif
            chk("occupancy", occupancy, cnt);
            chk("in_ready", in_bus.ready, cnt < 2);
            chk("out_valid", out_bus.valid, cnt > 0);
            chk("out_en_n", out_en_n, !(cnt > 0 && out_bus.ready && !f));
            if (cnt > 0) begin
                if (exp_q.size() == 0) chk("scoreboard_underflow", 0, 1);
                else chk("out_data", out_bus.data, exp_q[0]);
            end
            ifire = in_bus.valid && (cnt < 2) && !f;
            ofire = (cnt > 0) && out_bus.ready && !f;
            if (f) begin
                cnt = 0;
                exp_q.delete();
            end else begin
                if (ofire && exp_q.size() > 0) void'(exp_q.pop_front());
                cnt = cnt + int'(ifire) - int'(ofire);
            end
        end
    end

    initial begin
        bit           acc;
        logic [W-1:0] payload;
        in_bus.valid  = 1'b0;
        in_bus.data   = '0;
        out_bus.ready = 1'b0;

        // Asynchronous reset asserted between clock edges.
        #3 rst_n = 1'b0;
        #1 chk_reset("reset");
        #13 rst_n = 1'b1;
        step(1'b0, 6'b0, 1'b0, 1'b0, acc);
        mon_en = 1'b1;

        // Pass-through at full rate.
        step(1'b1, 6'b011011, 1'b1, 1'b0, acc);
        step(1'b1, 6'b100100, 1'b1, 1'b0, acc);
        step(1'b1, 6'b111000, 1'b1, 1'b0, acc);
        step(1'b0, 6'b0, 1'b1, 1'b0, acc);
        step(1'b0, 6'b0, 1'b1, 1'b0, acc);

        // Skid fill, hold while full, then drain.
        step(1'b1, 6'b011011, 1'b0, 1'b0, acc);
        step(1'b1, 6'b000111, 1'b0, 1'b0, acc);
        step(1'b1, 6'b101010, 1'b0, 1'b0, acc);
        step(1'b0, 6'b0, 1'b0, 1'b0, acc);
        step(1'b0, 6'b0, 1'b1, 1'b0, acc);
        step(1'b0, 6'b0, 1'b1, 1'b0, acc);
        step(1'b0, 6'b0, 1'b0, 1'b0, acc);

        // Random handshake; producer holds a beat until it is taken.
        payload = 6'd1;
        for (int i = 0; i < 200; i++) begin
            step(($urandom % 4) != 0, payload, ($urandom % 3) != 0, 1'b0, acc);
            if (acc) payload = payload + 6'd1;
        end
        for (int i = 0; i < 6; i++) step(1'b1, payload, 1'b0, 1'b0, acc);
        for (int i = 0; i < 4; i++) step(1'b0, 6'b0, 1'b1, 1'b0, acc);
        @(negedge clk);
        #1 chk("drained_queue", exp_q.size(), 0);

        // Reset mid-operation while full.
        step(1'b1, 6'b110011, 1'b0, 1'b0, acc);
        step(1'b1, 6'b001100, 1'b0, 1'b0, acc);
        @(negedge clk);
        #2;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        in_bus.valid = 1'b0;
        #1 chk_reset("midreset");
        @(posedge clk);
        #2 chk_reset("midreset_held");
        rst_n = 1'b1;
        cnt   = 0;
        exp_q.delete();
        step(1'b0, 6'b0, 1'b1, 1'b0, acc);
        mon_en = 1'b1;
        step(1'b1, 6'b010101, 1'b1, 1'b0, acc);
        step(1'b0, 6'b0, 1'b1, 1'b0, acc);

`ifdef PIPE_SKID_FLUSH_EN
        // Flush from FULL with a beat offered; that beat must never appear.
        step(1'b1, 6'b100001, 1'b0, 1'b0, acc);
        step(1'b1, 6'b010010, 1'b0, 1'b0, acc);
        step(1'b1, 6'b001111, 1'b1, 1'b1, acc);
        step(1'b0, 6'b0, 1'b1, 1'b0, acc);
        step(1'b1, 6'b111111, 1'b1, 1'b0, acc);
        step(1'b0, 6'b0, 1'b1, 1'b0, acc);
`endif

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
